// File: rtl/hex_parser.sv
// Registered ASCII-hex string to binary converter, one result per accepted input.
// Build option: define HEX_PARSER_LOWER_EN to accept lowercase "a"-"f" as hex digits.
module hex_parser #(
  parameter int L = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [16*L-1:0]  str,
  output logic             out_valid,
  output logic [8*L-1:0]   num,
  output logic             err,
  output logic [2*L-1:0]   bad_mask
);

  logic [8*L-1:0] num_next;
  logic [2*L-1:0] bad_next;

  // Returns {illegal, nibble}; an illegal character yields nibble 0.
  // For both letter ranges the low four bits of the code plus 9 give 10..15.
  function automatic logic [4:0] decode_char(input logic [7:0] c);
    logic [4:0] res;
    res = {1'b1, 4'h0};
    if (c >= 8'h30 && c <= 8'h39)
      res = {1'b0, c[3:0]};
    else if (c >= 8'h41 && c <= 8'h46)
      res = {1'b0, c[3:0] + 4'd9};
`ifdef HEX_PARSER_LOWER_EN
    else if (c >= 8'h61 && c <= 8'h66)
      res = {1'b0, c[3:0] + 4'd9};
`else
    else
      res = {1'b1, 4'h0};
`endif
    return res;
  endfunction

  // Character occupying byte j of str maps directly onto nibble j of num.
  always_comb begin
    logic [4:0] dec;
    num_next = '0;
    bad_next = '0;
    dec      = '0;
    for (int j = 0; j < 2*L; j++) begin
      dec              = decode_char(str[8*j +: 8]);
      num_next[4*j +: 4] = dec[3:0];
      bad_next[j]        = dec[4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      num       <= '0;
      err       <= 1'b0;
      bad_mask  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        num      <= num_next;
        err      <= |bad_next;
        bad_mask <= bad_next;
      end
    end
  end

endmodule

// File: tb/tb_hex_parser.sv
// Self-checking bench for hex_parser at L = 1, 2 and 4, using a string-parsing reference model.
module tb_hex_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid1 = 1'b0;
  logic [15:0] str1 = '0;
  logic        out_valid1;
  logic [7:0]  num1;
  logic        err1;
  logic [1:0]  bad1;

  logic        in_valid2 = 1'b0;
  logic [31:0] str2 = '0;
  logic        out_valid2;
  logic [15:0] num2;
  logic        err2;
  logic [3:0]  bad2;

  logic        in_valid4 = 1'b0;
  logic [63:0] str4 = '0;
  logic        out_valid4;
  logic [31:0] num4;
  logic        err4;
  logic [7:0]  bad4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hex_parser #(.L(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .str(str1),
    .out_valid(out_valid1), .num(num1), .err(err1), .bad_mask(bad1)
  );

  hex_parser #(.L(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .str(str2),
    .out_valid(out_valid2), .num(num2), .err(err2), .bad_mask(bad2)
  );

  hex_parser #(.L(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .str(str4),
    .out_valid(out_valid4), .num(num4), .err(err4), .bad_mask(bad4)
  );

  // Parses the string left to right like a human reading it: value = value*16 + digit.
  function automatic void ref_parse(input logic [63:0] s, input int n_chars,
                                    output logic [31:0] value, output logic [7:0] bad);
    logic [7:0] c;
    int d;
    bit ok;
    value = 0;
    bad   = 0;
    for (int k = 0; k < n_chars; k++) begin
      c  = s[8*(n_chars-1-k) +: 8];
      ok = 1'b1;
      d  = 0;
      if (c >= "0" && c <= "9") d = c - "0";
      else if (c >= "A" && c <= "F") d = c - "A" + 10;
`ifdef HEX_PARSER_LOWER_EN
      else if (c >= "a" && c <= "f") d = c - "a" + 10;
`endif
      else ok = 1'b0;
      value = value * 16 + d;
      if (!ok) bad[n_chars-1-k] = 1'b1;
    end
  endfunction

  function automatic logic [7:0] rand_char();
    case ($urandom_range(0, 3))
      0: return 8'("0" + $urandom_range(0, 9));
      1: return 8'("A" + $urandom_range(0, 5));
      2: return 8'("a" + $urandom_range(0, 5));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic apply_stimulus2(input logic v, input logic [31:0] s);
    in_valid2 = v;
    str2      = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_valid1 = 1'b1; str1 = "FF";
    in_valid4 = 1'b1; str4 = "FFFFFFFF";
    for (int i = 0; i < 3; i++) begin
      apply_stimulus2(1'b1, "FFFF");
      checks += 4;
      if (num2 !== 16'h0) begin failures++; $display("[TB] FAIL reset_num got=%h want=0000", num2); end
      if (err2 !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b want=0", err2); end
      if (bad2 !== 4'h0) begin failures++; $display("[TB] FAIL reset_bad got=%b want=0000", bad2); end
      if (out_valid2 !== 1'b0 || out_valid1 !== 1'b0 || out_valid4 !== 1'b0) begin
        failures++; $display("[TB] FAIL reset_out_valid got=%b%b%b want=000", out_valid1, out_valid2, out_valid4);
      end
    end
    in_valid1 = 1'b0; in_valid2 = 1'b0; in_valid4 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] strs [5] = '{"7F7C", "7070", "FFFF", "0000", "6A9C"};
    logic [15:0] nums [5] = '{16'h7F7C, 16'h7070, 16'hFFFF, 16'h0000, 16'h6A9C};
    for (int i = 0; i < 5; i++) begin
      apply_stimulus2(1'b1, strs[i]);
      checks += 3;
      if (num2 !== nums[i]) begin failures++; $display("[TB] FAIL b2b_num[%0d] got=%h want=%h", i, num2, nums[i]); end
      if (err2 !== 1'b0) begin failures++; $display("[TB] FAIL b2b_err[%0d] got=%b want=0", i, err2); end
      if (out_valid2 !== 1'b1) begin failures++; $display("[TB] FAIL b2b_out_valid[%0d] got=%b want=1", i, out_valid2); end
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 2; i++) begin
      apply_stimulus2(1'b0, i == 0 ? 32'("1234") : 32'("G0G0"));
      checks += 2;
      if (num2 !== 16'h6A9C) begin failures++; $display("[TB] FAIL hold_num got=%h want=6a9c", num2); end
      if (out_valid2 !== 1'b0) begin failures++; $display("[TB] FAIL hold_out_valid got=%b want=0", out_valid2); end
    end
  endtask

  task automatic test_illegal();
    apply_stimulus2(1'b1, "7G7 ");
    checks += 3;
    if (num2 !== 16'h7070) begin failures++; $display("[TB] FAIL illegal_num got=%h want=7070", num2); end
    if (bad2 !== 4'b0101) begin failures++; $display("[TB] FAIL illegal_bad got=%b want=0101", bad2); end
    if (err2 !== 1'b1) begin failures++; $display("[TB] FAIL illegal_err got=%b want=1", err2); end
    apply_stimulus2(1'b1, "1234");
    checks += 3;
    if (num2 !== 16'h1234) begin failures++; $display("[TB] FAIL recover_num got=%h want=1234", num2); end
    if (bad2 !== 4'b0000) begin failures++; $display("[TB] FAIL recover_bad got=%b want=0000", bad2); end
    if (err2 !== 1'b0) begin failures++; $display("[TB] FAIL recover_err got=%b want=0", err2); end
  endtask

  task automatic test_lowercase();
    logic [15:0] want_num;
    logic [3:0]  want_bad;
`ifdef HEX_PARSER_LOWER_EN
    want_num = 16'h6A9C; want_bad = 4'b0000;
`else
    want_num = 16'h6090; want_bad = 4'b0101;
`endif
    apply_stimulus2(1'b1, "6a9c");
    checks += 3;
    if (num2 !== want_num) begin failures++; $display("[TB] FAIL lower_num got=%h want=%h", num2, want_num); end
    if (bad2 !== want_bad) begin failures++; $display("[TB] FAIL lower_bad got=%b want=%b", bad2, want_bad); end
    if (err2 !== (|want_bad)) begin failures++; $display("[TB] FAIL lower_err got=%b want=%b", err2, |want_bad); end
    in_valid2 = 1'b0;
  endtask

  task automatic test_width();
    in_valid1 = 1'b1; str1 = "A5";
    in_valid4 = 1'b1; str4 = "DEADBEEF";
    @(posedge clk); #1;
    in_valid1 = 1'b0; in_valid4 = 1'b0;
    checks += 5;
    if (num1 !== 8'hA5) begin failures++; $display("[TB] FAIL width1_num got=%h want=a5", num1); end
    if (err1 !== 1'b0) begin failures++; $display("[TB] FAIL width1_err got=%b want=0", err1); end
    if (num4 !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL width4_num got=%h want=deadbeef", num4); end
    if (err4 !== 1'b0) begin failures++; $display("[TB] FAIL width4_err got=%b want=0", err4); end
    if (out_valid4 !== 1'b1) begin failures++; $display("[TB] FAIL width4_out_valid got=%b want=1", out_valid4); end
  endtask

  task automatic test_async_reset();
    apply_stimulus2(1'b1, "FFFF");
    in_valid2 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks += 3;
    if (num2 !== 16'h0) begin failures++; $display("[TB] FAIL async_num got=%h want=0000", num2); end
    if (out_valid2 !== 1'b0) begin failures++; $display("[TB] FAIL async_out_valid got=%b want=0", out_valid2); end
    if (bad2 !== 4'h0 || err2 !== 1'b0) begin failures++; $display("[TB] FAIL async_err got=%b/%b want=0/0000", err2, bad2); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [31:0] exp2_num = 0, exp4_num = 0, n;
    logic [7:0]  exp2_bad = 0, exp4_bad = 0, b;
    logic        v2, v4;
    logic [31:0] s2;
    logic [63:0] s4;
    for (int i = 0; i < 60; i++) begin
      v2 = 1'($urandom_range(0, 3) != 0);
      v4 = 1'($urandom_range(0, 1));
      for (int k = 0; k < 4; k++) s2[8*k +: 8] = rand_char();
      for (int k = 0; k < 8; k++) s4[8*k +: 8] = rand_char();
      in_valid4 = v4; str4 = s4;
      apply_stimulus2(v2, s2);
      if (v2) begin ref_parse({32'h0, s2}, 4, n, b); exp2_num = n; exp2_bad = b; end
      if (v4) begin ref_parse(s4, 8, n, b); exp4_num = n; exp4_bad = b; end
      checks += 8;
      if (num2 !== exp2_num[15:0]) begin failures++; $display("[TB] FAIL rand2_num[%0d] got=%h want=%h", i, num2, exp2_num[15:0]); end
      if (bad2 !== exp2_bad[3:0]) begin failures++; $display("[TB] FAIL rand2_bad[%0d] got=%b want=%b", i, bad2, exp2_bad[3:0]); end
      if (err2 !== (|exp2_bad)) begin failures++; $display("[TB] FAIL rand2_err[%0d] got=%b want=%b", i, err2, |exp2_bad); end
      if (out_valid2 !== v2) begin failures++; $display("[TB] FAIL rand2_out_valid[%0d] got=%b want=%b", i, out_valid2, v2); end
      if (num4 !== exp4_num) begin failures++; $display("[TB] FAIL rand4_num[%0d] got=%h want=%h", i, num4, exp4_num); end
      if (bad4 !== exp4_bad) begin failures++; $display("[TB] FAIL rand4_bad[%0d] got=%b want=%b", i, bad4, exp4_bad); end
      if (err4 !== (|exp4_bad)) begin failures++; $display("[TB] FAIL rand4_err[%0d] got=%b want=%b", i, err4, |exp4_bad); end
      if (out_valid4 !== v4) begin failures++; $display("[TB] FAIL rand4_out_valid[%0d] got=%b want=%b", i, out_valid4, v4); end
    end
    in_valid2 = 1'b0; in_valid4 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_hold();
    test_illegal();
    test_lowercase();
    test_width();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
